// File: rtl/tank_pkg.sv
// Shared types, USB key codes and arithmetic helpers for the tank, bullet and menu blocks.
package tank_pkg;

  typedef enum logic [0:0] {
    ALIVE = 1'b0,
    DEAD  = 1'b1
  } tank_state_t;

  // USB HID usage codes for arrow keys and space bar.
  localparam logic [7:0] USB_UP    = 8'h52;
  localparam logic [7:0] USB_DOWN  = 8'h51;
  localparam logic [7:0] USB_LEFT  = 8'h50;
  localparam logic [7:0] USB_RIGHT = 8'h4F;
  localparam logic [7:0] USB_SPACE = 8'h2C;

  localparam int POS_W  = 14;
  localparam int FRAC_W = 4;

  // Sign-magnitude Q0.7 value times an unsigned factor; the magnitude is truncated
  // before the sign is applied, so +x and -x always yield symmetric results.
  function automatic logic signed [15:0] sm_scale(input logic [7:0] sm, input logic [7:0] u);
    logic [15:0] mag;
    mag = ({8'b0, u} * {9'b0, sm[6:0]}) >> 7;
    if (sm[7]) sm_scale = -$signed(mag);
    else       sm_scale = $signed(mag);
  endfunction

endpackage

// File: rtl/tank_ctrl_if.sv
// Bundle between a tank controller and its environment (keyboard, trig LUT, bullet manager, renderer).
interface tank_ctrl_if
  import tank_pkg::*;
#(
    parameter int ANGLE_W = 6
);
    logic [31:0]        keycode;
    logic [7:0]         sin;
    logic [7:0]         cos;
    logic               hit;
    logic               fire_ack;
    logic [9:0]         TankX;
    logic [9:0]         TankY;
    logic [9:0]         TankS;
    logic [ANGLE_W-1:0] Angle;
    logic               fire_req;
    logic               alive;
    tank_state_t        state;

    // fire_req is the valid, fire_ack the ready: the request stays high until an
    // edge sees both high, and that edge alone completes the shot.
    modport master (
        input  keycode, sin, cos, hit, fire_ack,
        output TankX, TankY, TankS, Angle, fire_req, alive, state
    );

    modport slave (
        output keycode, sin, cos, hit, fire_ack,
        input  TankX, TankY, TankS, Angle, fire_req, alive, state
    );
endinterface

// File: rtl/tank_keymap.sv
// Combinational key-map decoder: a function bit is set if any of the four keycode slots matches it.
module tank_keymap
  import tank_pkg::*;
#(
    parameter logic [7:0] KEY_FWD   = USB_UP,
    parameter logic [7:0] KEY_BACK  = USB_DOWN,
    parameter logic [7:0] KEY_LEFT  = USB_LEFT,
    parameter logic [7:0] KEY_RIGHT = USB_RIGHT,
    parameter logic [7:0] KEY_FIRE  = USB_SPACE
) (
    input  logic [31:0] keycode,
    output logic        fwd,
    output logic        back,
    output logic        left,
    output logic        right,
    output logic        fire
);

    always_comb begin
        fwd   = 1'b0;
        back  = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        fire  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (keycode[8*i +: 8] == KEY_FWD)   fwd   = 1'b1;
            if (keycode[8*i +: 8] == KEY_BACK)  back  = 1'b1;
            if (keycode[8*i +: 8] == KEY_LEFT)  left  = 1'b1;
            if (keycode[8*i +: 8] == KEY_RIGHT) right = 1'b1;
            if (keycode[8*i +: 8] == KEY_FIRE)  fire  = 1'b1;
        end
    end

endmodule

// File: rtl/tank_ctrl.sv
// Per-player tank: key-driven heading and Q10.4 motion with edge clamping,
// fire request with cooldown, and an alive/dead/respawn state machine.
module tank_ctrl
  import tank_pkg::*;
#(
    parameter logic [7:0] KEY_FWD        = USB_UP,
    parameter logic [7:0] KEY_BACK       = USB_DOWN,
    parameter logic [7:0] KEY_LEFT       = USB_LEFT,
    parameter logic [7:0] KEY_RIGHT      = USB_RIGHT,
    parameter logic [7:0] KEY_FIRE       = USB_SPACE,
    parameter int         N_ANGLES       = 45,
    parameter int         ANGLE_W        = 6,
    parameter logic [7:0] SPEED_Q4       = 8'd32,
    parameter int         ROT_DIV        = 2,
    parameter int         SIZE           = 10,
    parameter int         X_MIN          = 0,
    parameter int         X_MAX          = 639,
    parameter int         Y_MIN          = 0,
    parameter int         Y_MAX          = 479,
    parameter int         X_START        = 300,
    parameter int         Y_START        = 250,
    parameter int         START_ANGLE    = 0,
    parameter int         FIRE_COOLDOWN  = 30,
    parameter int         RESPAWN_FRAMES = 120
) (
    input  logic        frame_clk,
    input  logic        Reset_n,
    tank_ctrl_if.master bus
);

    localparam logic [POS_W-1:0]   X_SPAWN    = POS_W'(X_START * 16);
    localparam logic [POS_W-1:0]   Y_SPAWN    = POS_W'(Y_START * 16);
    localparam logic [ANGLE_W-1:0] ANG_SPAWN  = ANGLE_W'(START_ANGLE);
    localparam logic [ANGLE_W-1:0] ANG_LAST   = ANGLE_W'(N_ANGLES - 1);
    localparam logic [7:0]         ROT_RELOAD = 8'(ROT_DIV - 1);
    localparam logic [15:0]        COOL_LOAD  = 16'(FIRE_COOLDOWN);
    localparam logic [15:0]        RESP_LOAD  = 16'(RESPAWN_FRAMES - 1);

    logic               fwd, back, left, right, fire;
    logic [POS_W-1:0]   pos_x, pos_y;
    logic [ANGLE_W-1:0] angle;
    logic [7:0]         rot_cnt;
    logic [15:0]        cooldown;
    logic [15:0]        resp_cnt;
    logic               fire_req;
    logic               alive;
    tank_state_t        state;

    logic signed [15:0] dx, dy, nx, ny;
    logic [POS_W-1:0]   nx_c, ny_c;
    logic [ANGLE_W-1:0] ang_inc, ang_dec;

    tank_keymap #(
        .KEY_FWD  (KEY_FWD),
        .KEY_BACK (KEY_BACK),
        .KEY_LEFT (KEY_LEFT),
        .KEY_RIGHT(KEY_RIGHT),
        .KEY_FIRE (KEY_FIRE)
    ) u_keymap (
        .keycode(bus.keycode),
        .fwd    (fwd),
        .back   (back),
        .left   (left),
        .right  (right),
        .fire   (fire)
    );

    // Integer part outside [lo, hi] snaps to the edge with the fraction cleared.
    function automatic logic [POS_W-1:0] clamp_q(input logic signed [15:0] v, input int lo,
                                                 input int hi);
        int iv;
        iv = int'(v >>> FRAC_W);
        if (iv < lo)      clamp_q = POS_W'(lo * 16);
        else if (iv > hi) clamp_q = POS_W'(hi * 16);
        else              clamp_q = v[POS_W-1:0];
    endfunction

    // Screen y grows downward, so forward motion subtracts the sine term.
    always_comb begin
        dx = '0;
        dy = '0;
        if (fwd && !back) begin
            dx = sm_scale(bus.cos, SPEED_Q4);
            dy = -sm_scale(bus.sin, SPEED_Q4);
        end else if (back && !fwd) begin
            dx = -sm_scale(bus.cos, SPEED_Q4);
            dy = sm_scale(bus.sin, SPEED_Q4);
        end
        nx      = $signed({2'b00, pos_x}) + dx;
        ny      = $signed({2'b00, pos_y}) + dy;
        nx_c    = clamp_q(nx, X_MIN + SIZE, X_MAX - SIZE);
        ny_c    = clamp_q(ny, Y_MIN + SIZE, Y_MAX - SIZE);
        ang_inc = (angle == ANG_LAST) ? '0 : angle + 1'b1;
        ang_dec = (angle == '0) ? ANG_LAST : angle - 1'b1;
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ALIVE;
            alive    <= 1'b1;
            pos_x    <= X_SPAWN;
            pos_y    <= Y_SPAWN;
            angle    <= ANG_SPAWN;
            rot_cnt  <= '0;
            cooldown <= '0;
            resp_cnt <= '0;
            fire_req <= 1'b0;
        end else begin
            if (cooldown != '0) cooldown <= cooldown - 16'd1;
            case (state)
                ALIVE: begin
                    if (bus.hit) begin
                        // The pose keeps its pre-edge value; nothing else moves this frame.
                        state    <= DEAD;
                        alive    <= 1'b0;
                        fire_req <= 1'b0;
                        resp_cnt <= RESP_LOAD;
                    end else begin
                        pos_x <= nx_c;
                        pos_y <= ny_c;
                        if (left ^ right) begin
                            if (rot_cnt == '0) begin
                                angle   <= left ? ang_inc : ang_dec;
                                rot_cnt <= ROT_RELOAD;
                            end else begin
                                rot_cnt <= rot_cnt - 8'd1;
                            end
                        end else begin
                            rot_cnt <= '0;
                        end
                        if (fire_req && bus.fire_ack) begin
                            fire_req <= 1'b0;
                            cooldown <= COOL_LOAD;
                        end else if (fire && cooldown == '0 && !fire_req) begin
                            fire_req <= 1'b1;
                        end
                    end
                end
                DEAD: begin
                    if (resp_cnt == '0) begin
                        state    <= ALIVE;
                        alive    <= 1'b1;
                        pos_x    <= X_SPAWN;
                        pos_y    <= Y_SPAWN;
                        angle    <= ANG_SPAWN;
                        cooldown <= '0;
                        rot_cnt  <= '0;
                    end else begin
                        resp_cnt <= resp_cnt - 16'd1;
                    end
                end
                default: state <= ALIVE;
            endcase
        end
    end

    assign bus.TankX    = pos_x[POS_W-1:FRAC_W];
    assign bus.TankY    = pos_y[POS_W-1:FRAC_W];
    assign bus.TankS    = 10'(SIZE);
    assign bus.Angle    = angle;
    assign bus.fire_req = fire_req;
    assign bus.alive    = alive;
    assign bus.state    = state;

endmodule

// File: tb/tb_tank_ctrl.sv
// Directed bench for tank_ctrl: reset pose, motion, clamping, rotation wrap, fire cooldown, death/respawn.
module tb_tank_ctrl;
    import tank_pkg::*;

    logic frame_clk = 1'b0;
    logic Reset_n   = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    tank_ctrl_if #(.ANGLE_W(6)) bus ();

    tank_ctrl dut (
        .frame_clk(frame_clk),
        .Reset_n  (Reset_n),
        .bus      (bus)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.keycode  = '0;
        bus.sin      = 8'h00;
        bus.cos      = 8'h7F;
        bus.hit      = 1'b0;
        bus.fire_ack = 1'b0;
        Reset_n      = 1'b0;
        tick(2);
        Reset_n = 1'b1;
        tick(1);
        vectors++; if (bus.TankX !== 10'd300) begin miscompares++; $display("FAIL reset_x got %0d want 300", bus.TankX); end
        vectors++; if (bus.TankY !== 10'd250) begin miscompares++; $display("FAIL reset_y got %0d want 250", bus.TankY); end
        vectors++; if (bus.Angle !== 6'd0) begin miscompares++; $display("FAIL reset_angle got %0d want 0", bus.Angle); end
        vectors++; if (bus.alive !== 1'b1) begin miscompares++; $display("FAIL reset_alive got %0b want 1", bus.alive); end
        vectors++; if (bus.fire_req !== 1'b0) begin miscompares++; $display("FAIL reset_fire_req got %0b want 0", bus.fire_req); end
        vectors++; if (bus.TankS !== 10'd10) begin miscompares++; $display("FAIL reset_size got %0d want 10", bus.TankS); end
    endtask

    // 32*127>>7 = 31 sixteenths per frame from 300.0
    task automatic test_forward();
        int exp_x[4];
        exp_x = '{301, 303, 305, 307};
        bus.keycode = {8'h00, USB_UP, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            tick(1);
            vectors++; if (bus.TankX !== 10'(exp_x[i])) begin miscompares++; $display("FAIL fwd_x[%0d] got %0d want %0d", i, bus.TankX, exp_x[i]); end
            vectors++; if (bus.TankY !== 10'd250) begin miscompares++; $display("FAIL fwd_y[%0d] got %0d want 250", i, bus.TankY); end
        end
        bus.keycode = {USB_DOWN, 8'h00, 8'h00, USB_UP};
        tick(3);
        vectors++; if (bus.TankX !== 10'd307) begin miscompares++; $display("FAIL fwd_back_x got %0d want 307", bus.TankX); end
        vectors++; if (bus.TankY !== 10'd250) begin miscompares++; $display("FAIL fwd_back_y got %0d want 250", bus.TankY); end
    endtask

    task automatic test_edges();
        bus.keycode = {24'h0, USB_UP};
        tick(200);
        vectors++; if (bus.TankX !== 10'd629) begin miscompares++; $display("FAIL right_edge_x got %0d want 629", bus.TankX); end
        tick(5);
        vectors++; if (bus.TankX !== 10'd629) begin miscompares++; $display("FAIL right_edge_hold got %0d want 629", bus.TankX); end
        // From 629.0 one reverse step lands at 627.0625.
        bus.keycode = {24'h0, USB_DOWN};
        tick(1);
        vectors++; if (bus.TankX !== 10'd627) begin miscompares++; $display("FAIL back_x got %0d want 627", bus.TankX); end
        bus.cos     = 8'h00;
        bus.sin     = 8'h7F;
        bus.keycode = {16'h0, USB_UP, 8'h00};
        tick(130);
        vectors++; if (bus.TankY !== 10'd10) begin miscompares++; $display("FAIL top_edge_y got %0d want 10", bus.TankY); end
        vectors++; if (bus.TankX !== 10'd627) begin miscompares++; $display("FAIL top_edge_x got %0d want 627", bus.TankX); end
        // Negative sine: forward now moves down, 10.0 + 31/16 -> 11.9375.
        bus.sin = 8'hFF;
        tick(1);
        vectors++; if (bus.TankY !== 10'd11) begin miscompares++; $display("FAIL neg_sin_y got %0d want 11", bus.TankY); end
    endtask

    task automatic test_rotation();
        int exp_r[3];
        int exp_l[3];
        exp_r = '{44, 44, 43};
        exp_l = '{44, 44, 0};
        bus.keycode = {24'h0, USB_RIGHT};
        for (int i = 0; i < 3; i++) begin
            tick(1);
            vectors++; if (bus.Angle !== 6'(exp_r[i])) begin miscompares++; $display("FAIL right_angle[%0d] got %0d want %0d", i, bus.Angle, exp_r[i]); end
        end
        bus.keycode = '0;
        tick(1);
        vectors++; if (bus.Angle !== 6'd43) begin miscompares++; $display("FAIL release_angle got %0d want 43", bus.Angle); end
        bus.keycode = {8'h00, USB_LEFT, 16'h0};
        for (int i = 0; i < 3; i++) begin
            tick(1);
            vectors++; if (bus.Angle !== 6'(exp_l[i])) begin miscompares++; $display("FAIL left_angle[%0d] got %0d want %0d", i, bus.Angle, exp_l[i]); end
        end
        bus.keycode = {USB_LEFT, 16'h0, USB_RIGHT};
        tick(2);
        vectors++; if (bus.Angle !== 6'd0) begin miscompares++; $display("FAIL both_rot_angle got %0d want 0", bus.Angle); end
        vectors++; if (bus.TankX !== 10'd627) begin miscompares++; $display("FAIL rot_no_move_x got %0d want 627", bus.TankX); end
    endtask

    // After the ack edge loads 30, the count reaches zero on the 30th edge and
    // the held key re-arms the request on the 31st.
    task automatic test_fire();
        int cnt;
        bus.keycode = {USB_SPACE, 24'h0};
        tick(1);
        vectors++; if (bus.fire_req !== 1'b1) begin miscompares++; $display("FAIL fire_first got %0b want 1", bus.fire_req); end
        tick(2);
        vectors++; if (bus.fire_req !== 1'b1) begin miscompares++; $display("FAIL fire_hold got %0b want 1", bus.fire_req); end
        bus.fire_ack = 1'b1;
        tick(1);
        bus.fire_ack = 1'b0;
        vectors++; if (bus.fire_req !== 1'b0) begin miscompares++; $display("FAIL fire_ack_drop got %0b want 0", bus.fire_req); end
        cnt = 0;
        while (bus.fire_req !== 1'b1 && cnt < 40) begin
            tick(1);
            cnt++;
        end
        vectors++; if (cnt != 31) begin miscompares++; $display("FAIL fire_repeat_gap got %0d want 31", cnt); end
    endtask

    task automatic test_hit_respawn();
        bus.cos     = 8'h7F;
        bus.sin     = 8'h00;
        bus.keycode = {USB_UP, USB_LEFT, USB_SPACE, 8'h00};
        bus.hit     = 1'b1;
        tick(1);
        bus.hit = 1'b0;
        vectors++; if (bus.alive !== 1'b0) begin miscompares++; $display("FAIL hit_alive got %0b want 0", bus.alive); end
        vectors++; if (bus.fire_req !== 1'b0) begin miscompares++; $display("FAIL hit_fire_req got %0b want 0", bus.fire_req); end
        vectors++; if (bus.state !== DEAD) begin miscompares++; $display("FAIL hit_state got %0d want %0d", bus.state, DEAD); end
        vectors++; if (bus.TankX !== 10'd627 || bus.TankY !== 10'd11 || bus.Angle !== 6'd0) begin
            miscompares++; $display("FAIL hit_pose got (%0d,%0d,%0d) want (627,11,0)", bus.TankX, bus.TankY, bus.Angle);
        end
        tick(59);
        bus.hit = 1'b1;
        tick(1);
        bus.hit = 1'b0;
        tick(59);
        vectors++; if (bus.alive !== 1'b0) begin miscompares++; $display("FAIL dead_119_alive got %0b want 0", bus.alive); end
        vectors++; if (bus.TankX !== 10'd627 || bus.TankY !== 10'd11 || bus.Angle !== 6'd0) begin
            miscompares++; $display("FAIL dead_pose got (%0d,%0d,%0d) want (627,11,0)", bus.TankX, bus.TankY, bus.Angle);
        end
        tick(1);
        vectors++; if (bus.alive !== 1'b1) begin miscompares++; $display("FAIL respawn_alive got %0b want 1", bus.alive); end
        vectors++; if (bus.TankX !== 10'd300 || bus.TankY !== 10'd250 || bus.Angle !== 6'd0) begin
            miscompares++; $display("FAIL respawn_pose got (%0d,%0d,%0d) want (300,250,0)", bus.TankX, bus.TankY, bus.Angle);
        end
        tick(1);
        vectors++; if (bus.fire_req !== 1'b1) begin miscompares++; $display("FAIL respawn_fire got %0b want 1", bus.fire_req); end
        vectors++; if (bus.Angle !== 6'd1) begin miscompares++; $display("FAIL respawn_rot got %0d want 1", bus.Angle); end
        vectors++; if (bus.TankX !== 10'd301) begin miscompares++; $display("FAIL respawn_move got %0d want 301", bus.TankX); end
    endtask

    task automatic test_reset_mid();
        bus.keycode = {16'h0, USB_UP, USB_SPACE};
        tick(2);
        #2;
        Reset_n = 1'b0;
        #1;
        vectors++; if (bus.TankX !== 10'd300 || bus.Angle !== 6'd0) begin
            miscompares++; $display("FAIL async_reset_pose got (%0d,%0d) want (300,0)", bus.TankX, bus.Angle);
        end
        vectors++; if (bus.fire_req !== 1'b0) begin miscompares++; $display("FAIL async_reset_fire got %0b want 0", bus.fire_req); end
        #1;
        Reset_n     = 1'b1;
        bus.keycode = '0;
        tick(1);
        bus.hit = 1'b1;
        tick(1);
        bus.hit = 1'b0;
        vectors++; if (bus.alive !== 1'b0) begin miscompares++; $display("FAIL dead_before_reset got %0b want 0", bus.alive); end
        tick(3);
        #2;
        Reset_n = 1'b0;
        #1;
        vectors++; if (bus.alive !== 1'b1 || bus.state !== ALIVE) begin
            miscompares++; $display("FAIL async_reset_dead got alive=%0b state=%0d want alive=1 state=%0d", bus.alive, bus.state, ALIVE);
        end
        #1;
        Reset_n = 1'b1;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_edges();
        test_rotation();
        test_fire();
        test_hit_respawn();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
